// File: rtl/pc_seq_pkg.sv
// Shared opcode and FSM state encodings for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JNO  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_HALT = 3'b101
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/ret_stack.sv
// LIFO return-address stack; the top entry is always presented on dout.
module ret_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem[AW'(cnt_q - CW'(1))];

  // Occupancy counter; push and pop are never requested together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage needs no reset: entries above the count are never read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[AW'(cnt_q)] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: jump, overflow-conditional jump, call/return
// through a bounded return stack, and a halt/resume FSM.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [OP_W-1:0]            instr,
  input  logic [WIDTH-1:0]           target,
  input  logic                       stall,
  input  logic                       resume,
  output logic [WIDTH-1:0]           pc,
  output logic                       ovf,
  output logic                       nop,
  output logic                       halted,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   pc_inc;
  logic             push, pop;
  logic [WIDTH-1:0] stk_dout;
  logic             stk_full, stk_empty;

  // Single WIDTH+1 bit add; the MSB is the wrap carry.
  assign pc_inc = {1'b0, pc_q} + (WIDTH + 1)'(1);

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc[WIDTH-1:0]),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty),
    .count (depth)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Every accepted opcode starts from the NOP increment and overrides it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ovf_d   = ovf_q;
    err_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (instr_valid) begin
            pc_d  = pc_inc[WIDTH-1:0];
            ovf_d = pc_inc[WIDTH];
            case (instr)
              OP_NOP: ;
              OP_JMP: begin
                pc_d  = target;
                ovf_d = 1'b0;
              end
              OP_JNO: begin
                if (!ovf_q) begin
                  pc_d  = target;
                  ovf_d = 1'b0;
                end
              end
              OP_CALL: begin
                if (!stk_full) begin
                  push  = 1'b1;
                  pc_d  = target;
                  ovf_d = 1'b0;
                end else begin
                  err_d = 1'b1;
                end
              end
              OP_RET: begin
                if (!stk_empty) begin
                  pop   = 1'b1;
                  pc_d  = stk_dout;
                  ovf_d = 1'b0;
                end else begin
                  err_d = 1'b1;
                end
              end
              OP_HALT: state_d = ST_HALT;
              default: err_d = 1'b1;
            endcase
          end
        end
        ST_HALT: begin
          if (resume) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign pc     = pc_q;
  assign ovf    = ovf_q;
  assign err    = err_q;
  assign halted = (state_q == ST_HALT);
  assign nop    = instr_valid && (instr == OP_NOP);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (WIDTH=8, DEPTH=4).
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [2:0] instr = 3'd0;
  logic [7:0] target = 8'd0;
  logic       stall = 1'b0;
  logic       resume = 1'b0;
  logic [7:0] pc;
  logic       ovf, nop, halted, err;
  logic [2:0] depth;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic       ovf;
    logic       err;
    logic [2:0] depth;
    logic       halted;
    logic       nop;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JNO = 3'd2, CALL = 3'd3,
                         RET = 3'd4, HLT = 3'd5, IL6 = 3'd6, IL7 = 3'd7;

  pc_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .target      (target),
    .stall       (stall),
    .resume      (resume),
    .pc          (pc),
    .ovf         (ovf),
    .nop         (nop),
    .halted      (halted),
    .err         (err),
    .depth       (depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, act, exp);
    end
  endtask

  // Monitor: one result per applied cycle, visible just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "pc", 32'(pc), 32'(e.pc));
        chk(e.name, "ovf", 32'(ovf), 32'(e.ovf));
        chk(e.name, "err", 32'(err), 32'(e.err));
        chk(e.name, "depth", 32'(depth), 32'(e.depth));
        chk(e.name, "halted", 32'(halted), 32'(e.halted));
        chk(e.name, "nop", 32'(nop), 32'(e.nop));
      end
    end
  end

  task automatic step(input string nm, input logic rn, input logic v,
                      input logic [2:0] op, input logic [7:0] tg,
                      input logic st, input logic rs,
                      input logic [7:0] epc, input logic eovf, input logic eerr,
                      input logic [2:0] edep, input logic ehalt);
    exp_t e;
    @(negedge clk);
    rst_n       = rn;
    instr_valid = v;
    instr       = op;
    target      = tg;
    stall       = st;
    resume      = rs;
    e.name   = nm;
    e.pc     = epc;
    e.ovf    = eovf;
    e.err    = eerr;
    e.depth  = edep;
    e.halted = ehalt;
    e.nop    = v && (op == NOP);
    sb.push_back(e);
  endtask

  initial begin
    int waited;
    //    name          rn v  op    tgt    st rs  pc     ovf err dep halt
    step("reset",       0, 0, NOP,  8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    step("nop1",        1, 1, NOP,  8'h00, 0, 0, 8'h01, 0, 0, 0, 0);
    step("nop2",        1, 1, NOP,  8'h00, 0, 0, 8'h02, 0, 0, 0, 0);
    step("nop3",        1, 1, NOP,  8'h00, 0, 0, 8'h03, 0, 0, 0, 0);
    step("jmp_fe",      1, 1, JMP,  8'hFE, 0, 0, 8'hFE, 0, 0, 0, 0);
    step("nop_ff",      1, 1, NOP,  8'h00, 0, 0, 8'hFF, 0, 0, 0, 0);
    step("nop_wrap",    1, 1, NOP,  8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
    step("jno_taken_no",1, 1, JNO,  8'h40, 0, 0, 8'h01, 0, 0, 0, 0);
    step("jno_taken",   1, 1, JNO,  8'h40, 0, 0, 8'h40, 0, 0, 0, 0);
    step("jmp_10",      1, 1, JMP,  8'h10, 0, 0, 8'h10, 0, 0, 0, 0);
    step("call1",       1, 1, CALL, 8'h20, 0, 0, 8'h20, 0, 0, 1, 0);
    step("call2",       1, 1, CALL, 8'h20, 0, 0, 8'h20, 0, 0, 2, 0);
    step("call3",       1, 1, CALL, 8'h20, 0, 0, 8'h20, 0, 0, 3, 0);
    step("call4",       1, 1, CALL, 8'h20, 0, 0, 8'h20, 0, 0, 4, 0);
    step("call_full",   1, 1, CALL, 8'h20, 0, 0, 8'h21, 0, 1, 4, 0);
    step("ret1",        1, 1, RET,  8'h00, 0, 0, 8'h21, 0, 0, 3, 0);
    step("ret2",        1, 1, RET,  8'h00, 0, 0, 8'h21, 0, 0, 2, 0);
    step("ret3",        1, 1, RET,  8'h00, 0, 0, 8'h21, 0, 0, 1, 0);
    step("ret4",        1, 1, RET,  8'h00, 0, 0, 8'h11, 0, 0, 0, 0);
    step("ret_empty",   1, 1, RET,  8'h00, 0, 0, 8'h12, 0, 1, 0, 0);
    step("jmp_05",      1, 1, JMP,  8'h05, 0, 0, 8'h05, 0, 0, 0, 0);
    step("halt",        1, 1, HLT,  8'h00, 0, 0, 8'h06, 0, 0, 0, 1);
    step("halt_nop",    1, 1, NOP,  8'h00, 0, 0, 8'h06, 0, 0, 0, 1);
    step("halt_jmp",    1, 1, JMP,  8'h80, 0, 0, 8'h06, 0, 0, 0, 1);
    step("resume_stall",1, 0, NOP,  8'h00, 1, 1, 8'h06, 0, 0, 0, 1);
    step("resume",      1, 0, NOP,  8'h00, 0, 1, 8'h06, 0, 0, 0, 0);
    step("nop_after",   1, 1, NOP,  8'h00, 0, 0, 8'h07, 0, 0, 0, 0);
    step("illegal6",    1, 1, IL6,  8'h00, 0, 0, 8'h08, 0, 1, 0, 0);
    step("illegal7",    1, 1, IL7,  8'h00, 0, 0, 8'h09, 0, 1, 0, 0);
    step("call_30",     1, 1, CALL, 8'h30, 0, 0, 8'h30, 0, 0, 1, 0);
    step("stall_call",  1, 1, CALL, 8'h30, 1, 0, 8'h30, 0, 0, 1, 0);
    step("ret_0a",      1, 1, RET,  8'h00, 0, 0, 8'h0A, 0, 0, 0, 0);
    step("jmp_ff",      1, 1, JMP,  8'hFF, 0, 0, 8'hFF, 0, 0, 0, 0);
    step("wrap2",       1, 1, NOP,  8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
    step("stall_nop",   1, 1, NOP,  8'h00, 1, 0, 8'h00, 1, 0, 0, 0);
    step("invalid",     1, 0, NOP,  8'h00, 0, 0, 8'h00, 1, 0, 0, 0);
    step("jno_ovf",     1, 1, JNO,  8'h40, 0, 0, 8'h01, 0, 0, 0, 0);
    step("rst_jmp",     0, 1, JMP,  8'h77, 0, 0, 8'h00, 0, 0, 0, 0);
    step("call_50",     1, 1, CALL, 8'h50, 0, 0, 8'h50, 0, 0, 1, 0);
    step("rst_call",    0, 1, CALL, 8'h60, 0, 0, 8'h00, 0, 0, 0, 0);
    step("nop_post",    1, 1, NOP,  8'h00, 0, 0, 8'h01, 0, 0, 0, 0);
    step("halt2",       1, 1, HLT,  8'h00, 0, 0, 8'h02, 0, 0, 0, 1);
    step("rst_halt",    0, 0, NOP,  8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
    step("ret_empty2",  1, 1, RET,  8'h00, 0, 0, 8'h01, 0, 1, 0, 0);
    @(negedge clk);
    instr_valid = 1'b0;
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the program-counter width in bits (minimum 2).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of return-stack entries (minimum 1).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 Port instr_valid  input  1  qualifies instr and target this cycle.
REQ-006 Port instr  input  3  is the opcode.
REQ-007 Port target  input  WIDTH  is the jump/call destination.
REQ-008 Port stall  input  1  freezes all state when high.
REQ-009 Port resume  input  1  leaves HALT.
REQ-010 Port pc  output  WIDTH  is the registered program counter.
REQ-011 Port ovf  output  1  is the registered carry of the last sequential increment.
REQ-012 Port nop  output  1  is the combinational decode: instr_valid high and instr==NOP.
REQ-013 Port halted  output  1  is high while in state HALT.
REQ-014 Port err  output  1  is a one-cycle registered error pulse.
REQ-015 Port depth  output  $clog2(DEPTH+1)  is the current return-stack occupancy.

Function
REQ-016 Opcodes SHALL be: 000 NOP, 001 JMP, 010 JNO, 011 CALL, 100 RET, 101 HALT; 110 and 111 are illegal.
REQ-017 The FSM SHALL have two states: RUN and HALT; reset enters RUN.
REQ-018 The block SHALL update state only in RUN, with stall low and instr_valid high; otherwise pc, ovf and stack are held and err is 0.
REQ-019 NOP SHALL set pc to pc+1 modulo 2^WIDTH and set ovf to the carry out (1 only on wrap from all-ones to 0).
REQ-020 JMP SHALL load pc with target and clear ovf.
REQ-021 JNO SHALL load target and clear ovf when ovf==0; when ovf==1 it SHALL behave as NOP.
REQ-022 CALL with the stack not full SHALL push pc+1 (mod 2^WIDTH), load target, clear ovf.
REQ-023 CALL with the stack full SHALL behave as NOP, leave the stack unchanged and pulse err.
REQ-024 RET with the stack not empty SHALL pop into pc and clear ovf.
REQ-025 RET with the stack empty SHALL behave as NOP and pulse err.
REQ-026 HALT SHALL apply the NOP increment, then enter HALT in the same edge.
REQ-027 Illegal opcodes SHALL behave as NOP and pulse err.
REQ-028 In HALT, instr_valid SHALL be ignored; resume high with stall low returns to RUN next edge with pc unchanged.
REQ-029 The result of every update SHALL be visible on pc, ovf, depth and err one cycle after the qualifying edge (latency 1).
REQ-030 Priority SHALL be: reset > stall > FSM state > opcode.

Reset
REQ-031 With rst_n low at a clock edge: pc=0, ovf=0, err=0, depth=0, state RUN, halted=0, stack contents don't-care.
REQ-032 Reset mid-operation SHALL abandon any pending action; no push or pop from the reset cycle is kept.

Structure
REQ-033 Opcode constants and FSM state encodings SHALL live in shared package pc_seq_pkg.
REQ-034 The return stack SHALL be a sub-module ret_stack (params WIDTH, DEPTH; push, pop, din, dout, full, empty, count).
REQ-035 The increment SHALL be one WIDTH+1-bit addition whose MSB is the carry.

Verification
REQ-036 Reset then 3x NOP -> pc 0,1,2,3; ovf 0; err 0.
REQ-037 JMP 0xFE, then NOP, then NOP -> pc 0xFE, 0xFF, 0x00 with ovf=1; then JNO 0x40 -> pc 0x01; then JNO 0x40 -> pc 0x40, ovf 0.
REQ-038 At pc=0x10, CALL 0x20 five times (DEPTH=4) -> depth 1..4 and pc 0x20 each time; fifth gives err=1, pc 0x21, depth 4; then 4x RET -> pc 0x21, 0x21, 0x21, 0x11; fifth RET -> err=1, pc 0x12.
REQ-039 HALT at pc=0x05 -> pc 0x06, halted=1; NOPs ignored; resume -> halted=0, pc 0x06; next NOP -> 0x07.
REQ-040 Stall high with CALL 0x30 valid -> pc, depth unchanged; rst_n low together with a valid JMP -> pc 0, depth 0, state RUN next cycle.
